// File: rtl/led_breathe.sv
// LED breathing PWM: ramps brightness up, holds, ramps down, holds, repeats.
// Define LED_BREATHE_GAMMA_EN to map level to duty through (level*level)>>N.
module led_breathe #(
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned STEP_PERIODS = 4,
  parameter int unsigned HOLD_PERIODS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic [2:0]          phase,
  output logic                period_start
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_e;

  localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
  localparam logic [15:0]         STEP_LAST = 16'(STEP_PERIODS - 1);
  localparam logic [15:0]         HOLD_LAST = 16'(HOLD_PERIODS - 1);

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [15:0]         step_cnt_q, step_cnt_d;
  logic                led_q, led_d;

  logic [PWM_BITS-1:0] duty_map;
  logic [PWM_BITS-1:0] duty_now;
  logic                period_end;

`ifdef LED_BREATHE_GAMMA_EN
  logic [2*PWM_BITS-1:0] lvl_ext;
  logic [2*PWM_BITS-1:0] lvl_sq;

  always_comb begin
    lvl_ext  = {{PWM_BITS{1'b0}}, level_q};
    lvl_sq   = lvl_ext * lvl_ext;
    duty_map = PWM_BITS'(lvl_sq >> PWM_BITS);
  end
`else
  always_comb begin
    duty_map = level_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pwm_cnt_q  <= '0;
      level_q    <= '0;
      duty_q     <= '0;
      step_cnt_q <= '0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwm_cnt_q  <= pwm_cnt_d;
      level_q    <= level_d;
      duty_q     <= duty_d;
      step_cnt_q <= step_cnt_d;
      led_q      <= led_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pwm_cnt_d    = pwm_cnt_q;
    level_d      = level_q;
    duty_d       = duty_q;
    step_cnt_d   = step_cnt_q;
    led_d        = 1'b0;
    period_start = (state_q != IDLE) && (pwm_cnt_q == '0);
    period_end   = (pwm_cnt_q == '1);
    // The compare on the first cycle of a period must already use the new duty.
    duty_now     = period_start ? duty_map : duty_q;

    if (state_q == IDLE) begin
      pwm_cnt_d  = '0;
      level_d    = '0;
      duty_d     = '0;
      step_cnt_d = '0;
      if (en) state_d = RAMP_UP;
    end else begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      if (period_start) duty_d = duty_map;
      led_d = (pwm_cnt_q < duty_now);

      if (period_end) begin
        case (state_q)
          RAMP_UP: begin
            if (step_cnt_q >= STEP_LAST) begin
              step_cnt_d = '0;
              if (level_q != LVL_MAX) level_d = level_q + 1'b1;
              if (level_q >= LVL_MAX - 1'b1) state_d = HOLD_HIGH;
            end else begin
              step_cnt_d = step_cnt_q + 1'b1;
            end
          end
          HOLD_HIGH: begin
            if (step_cnt_q >= HOLD_LAST) state_d = RAMP_DOWN;
            else step_cnt_d = step_cnt_q + 1'b1;
          end
          RAMP_DOWN: begin
            if (step_cnt_q >= STEP_LAST) begin
              step_cnt_d = '0;
              if (level_q != '0) level_d = level_q - 1'b1;
              if (level_q <= 1) state_d = HOLD_LOW;
            end else begin
              step_cnt_d = step_cnt_q + 1'b1;
            end
          end
          HOLD_LOW: begin
            if (step_cnt_q >= HOLD_LAST) state_d = RAMP_UP;
            else step_cnt_d = step_cnt_q + 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end

      if (state_d != state_q) step_cnt_d = '0;
    end

    // Disable wins over any boundary transition and darkens the LED immediately.
    if (!en) begin
      state_d    = IDLE;
      pwm_cnt_d  = '0;
      level_d    = '0;
      duty_d     = '0;
      step_cnt_d = '0;
      led_d      = 1'b0;
    end
  end

  assign led   = led_q;
  assign level = level_q;
  assign phase = state_q;

endmodule

// File: tb/tb_led_breathe.sv
// Directed scoreboard bench for led_breathe with N=4, STEP_PERIODS=2, HOLD_PERIODS=3.
module tb_led_breathe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       led;
  logic [3:0] level;
  logic [2:0] phase;
  logic       period_start;

  led_breathe #(
    .PWM_BITS    (4),
    .STEP_PERIODS(2),
    .HOLD_PERIODS(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .led         (led),
    .level       (level),
    .phase       (phase),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    sig;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   t           = 0;
  int   led_cnt     = 0;
  int   ps_cnt      = 0;

  localparam int S_PHASE = 0, S_LEVEL = 1, S_LED = 2, S_PS = 3, S_LEDCNT = 4, S_PSCNT = 5;

  function automatic int duty_of(input int l);
`ifdef LED_BREATHE_GAMMA_EN
    return (l * l) >> 4;
`else
    return l;
`endif
  endfunction

  function automatic int obs_of(input int sig);
    case (sig)
      S_PHASE:  return int'(phase);
      S_LEVEL:  return int'(level);
      S_LED:    return int'(led);
      S_PS:     return int'(period_start);
      S_LEDCNT: return led_cnt;
      default:  return ps_cnt;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input int exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    int   o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs_of(e.sig);
      vectors++;
      assert (o === e.exp) else begin
        miscompares++;
        $error("FAIL %s (t=%0d): observed %0d expected %0d", e.tag, t, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic advance_to(input int target);
    while (t < target) tick();
  endtask

  task automatic measure(input int n);
    led_cnt = 0;
    ps_cnt  = 0;
    repeat (n) begin
      tick();
      led_cnt += int'(led);
      ps_cnt  += int'(period_start);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) tick();
    expect_val("rst_phase", S_PHASE, 0);
    expect_val("rst_level", S_LEVEL, 0);
    expect_val("rst_led",   S_LED,   0);
    expect_val("rst_ps",    S_PS,    0);
    check_sb();

    // Release reset with en high: RAMP_UP on the first cycle.
    rst = 1'b0;
    en  = 1'b1;
    tick();
    t = 0;
    expect_val("start_phase", S_PHASE, 1);
    expect_val("start_level", S_LEVEL, 0);
    expect_val("start_ps",    S_PS,    1);
    expect_val("start_led",   S_LED,   0);
    check_sb();

    advance_to(31);
    expect_val("pre_step_level", S_LEVEL, 0);
    expect_val("pre_step_ps",    S_PS,    0);
    check_sb();
    advance_to(32);
    expect_val("step1_level", S_LEVEL, 1);
    expect_val("step1_ps",    S_PS,    1);
    check_sb();

    advance_to(224);
    expect_val("lvl7_level", S_LEVEL, 7);
    check_sb();
    expect_val("lvl7_led_cnt", S_LEDCNT, duty_of(7));
    expect_val("lvl7_ps_cnt",  S_PSCNT,  1);
    measure(16);
    check_sb();

    advance_to(479);
    expect_val("pre_top_level", S_LEVEL, 14);
    expect_val("pre_top_phase", S_PHASE, 1);
    check_sb();
    advance_to(480);
    expect_val("top_level", S_LEVEL, 15);
    expect_val("top_phase", S_PHASE, 2);
    check_sb();
    expect_val("lvl15_led_cnt", S_LEDCNT, duty_of(15));
    expect_val("lvl15_ps_cnt",  S_PSCNT,  1);
    measure(16);
    check_sb();

    advance_to(527);
    expect_val("hold_hi_end_phase", S_PHASE, 2);
    check_sb();
    advance_to(528);
    expect_val("rdown_phase", S_PHASE, 3);
    expect_val("rdown_level", S_LEVEL, 15);
    check_sb();
    advance_to(560);
    expect_val("rdown_step_level", S_LEVEL, 14);
    check_sb();

    advance_to(1007);
    expect_val("pre_bottom_level", S_LEVEL, 1);
    expect_val("pre_bottom_phase", S_PHASE, 3);
    check_sb();
    advance_to(1008);
    expect_val("bottom_level", S_LEVEL, 0);
    expect_val("bottom_phase", S_PHASE, 4);
    check_sb();
    expect_val("lvl0_led_cnt", S_LEDCNT, 0);
    expect_val("lvl0_ps_cnt",  S_PSCNT,  1);
    measure(16);
    check_sb();

    advance_to(1055);
    expect_val("hold_lo_end_phase", S_PHASE, 4);
    check_sb();
    advance_to(1056);
    expect_val("cycle_phase", S_PHASE, 1);
    expect_val("cycle_level", S_LEVEL, 0);
    expect_val("cycle_ps",    S_PS,    1);
    check_sb();

    // Drop en on a step boundary inside the second RAMP_DOWN.
    advance_to(1615);
    expect_val("pre_drop_phase", S_PHASE, 3);
    expect_val("pre_drop_level", S_LEVEL, 15);
    check_sb();
    en = 1'b0;
    tick();
    expect_val("drop_phase", S_PHASE, 0);
    expect_val("drop_level", S_LEVEL, 0);
    expect_val("drop_led",   S_LED,   0);
    expect_val("drop_ps",    S_PS,    0);
    check_sb();
    tick();
    expect_val("idle_phase", S_PHASE, 0);
    check_sb();

    // Reset pulse during HOLD_HIGH.
    en = 1'b1;
    tick();
    t = 0;
    expect_val("restart_phase", S_PHASE, 1);
    check_sb();
    advance_to(500);
    expect_val("hold_mid_phase", S_PHASE, 2);
    expect_val("hold_mid_level", S_LEVEL, 15);
    check_sb();
    rst = 1'b1;
    tick();
    expect_val("midrst_phase", S_PHASE, 0);
    expect_val("midrst_level", S_LEVEL, 0);
    expect_val("midrst_led",   S_LED,   0);
    expect_val("midrst_ps",    S_PS,    0);
    check_sb();
    tick();
    expect_val("rst_prio_phase", S_PHASE, 0);
    check_sb();
    rst = 1'b0;
    tick();
    t = 0;
    expect_val("rel_phase", S_PHASE, 1);
    expect_val("rel_level", S_LEVEL, 0);
    expect_val("rel_ps",    S_PS,    1);
    check_sb();
    advance_to(32);
    expect_val("rel_step_level", S_LEVEL, 1);
    check_sb();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
